icc_branch_unit: RTL and testbench

- Downstream consumer of the ALU's N/Z/V/C flags in the SPARC V8 integer pipeline.
- Holds the PSR integer condition codes (icc), updated by cc-setting ops (ADDcc…SUBXcc) and by WRPSR.
- Feeds C back to the ALU carry input.
- Evaluates Bicc conditions and runs a delay-slot state machine that flags annulled delay-slot instructions.

---
 rtl/sparc_pkg.sv | 66 ++++++
 rtl/bicc_cond_eval.sv | 44 ++++
 rtl/icc_branch_unit.sv | 93 +++++++++
 tb/tb_icc_branch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// ============================================================================
// Module : sparc_pkg
// Brief  : Shared SPARC V8 integer constants for the branch/icc unit.
//          Covers Bicc conds, op/op3 codes, the state type and icc bit indices.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_pkg;

    localparam logic [3:0] COND_BN   = 4'h0;
    localparam logic [3:0] COND_BE   = 4'h1;
    localparam logic [3:0] COND_BLE  = 4'h2;
    localparam logic [3:0] COND_BL   = 4'h3;
    localparam logic [3:0] COND_BLEU = 4'h4;
    localparam logic [3:0] COND_BCS  = 4'h5;
    localparam logic [3:0] COND_BNEG = 4'h6;
    localparam logic [3:0] COND_BVS  = 4'h7;
    localparam logic [3:0] COND_BA   = 4'h8;
    localparam logic [3:0] COND_BNE  = 4'h9;
    localparam logic [3:0] COND_BG   = 4'hA;
    localparam logic [3:0] COND_BGE  = 4'hB;
    localparam logic [3:0] COND_BGU  = 4'hC;
    localparam logic [3:0] COND_BCC  = 4'hD;
    localparam logic [3:0] COND_BPOS = 4'hE;
    localparam logic [3:0] COND_BVC  = 4'hF;

    localparam logic [1:0] OP_ARITH = 2'b10;

    localparam logic [5:0] OP3_ADDCC  = 6'h10;
    localparam logic [5:0] OP3_ANDCC  = 6'h11;
    localparam logic [5:0] OP3_ORCC   = 6'h12;
    localparam logic [5:0] OP3_XORCC  = 6'h13;
    localparam logic [5:0] OP3_SUBCC  = 6'h14;
    localparam logic [5:0] OP3_ANDNCC = 6'h15;
    localparam logic [5:0] OP3_ORNCC  = 6'h16;
    localparam logic [5:0] OP3_XNORCC = 6'h17;
    localparam logic [5:0] OP3_ADDXCC = 6'h18;
    localparam logic [5:0] OP3_SUBXCC = 6'h1C;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DSLOT  = 2'd1,
        ANNUL  = 2'd2
    } bu_state_t;

    localparam int unsigned ICC_N = 3;
    localparam int unsigned ICC_Z = 2;
    localparam int unsigned ICC_V = 1;
    localparam int unsigned ICC_C = 0;

    function automatic logic is_cc_op(input logic [1:0] op, input logic [5:0] op3);
        logic w_hit;
        w_hit = 1'b0;
        case (op3)
            OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_XORCC,
            OP3_SUBCC, OP3_ANDNCC, OP3_ORNCC, OP3_XNORCC,
            OP3_ADDXCC, OP3_SUBXCC: w_hit = 1'b1;
            default:                w_hit = 1'b0;
        endcase
        return (op == OP_ARITH) && w_hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bicc_cond_eval.sv
// ============================================================================
// Module : bicc_cond_eval
// Brief  : Combinational Bicc condition evaluator (cond + icc -> taken).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bicc_cond_eval
    import sparc_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_icc,
    output logic       o_taken
);

    logic w_n, w_z, w_v, w_c;
    logic w_base;

    assign w_n = i_icc[ICC_N];
    assign w_z = i_icc[ICC_Z];
    assign w_v = i_icc[ICC_V];
    assign w_c = i_icc[ICC_C];

    // Upper half of the cond space is the complement of the lower half.
    always_comb begin
        w_base = 1'b0;
        case (i_cond[2:0])
            3'd0: w_base = 1'b0;
            3'd1: w_base = w_z;
            3'd2: w_base = w_z | (w_n ^ w_v);
            3'd3: w_base = w_n ^ w_v;
            3'd4: w_base = w_c | w_z;
            3'd5: w_base = w_c;
            3'd6: w_base = w_n;
            3'd7: w_base = w_v;
            default: w_base = 1'b0;
        endcase
    end

    assign o_taken = w_base ^ i_cond[3];

endmodule

`default_nettype wire

// File: rtl/icc_branch_unit.sv
// ============================================================================
// Module : icc_branch_unit
// Brief  : PSR icc register, Bicc evaluation and delay-slot annul tracking.
//          Optional macro ICC_BYPASS_EN forwards same-cycle ALU flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icc_branch_unit
    import sparc_pkg::*;
#(
    parameter logic [3:0] RESET_ICC = 4'b0000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       En,
    input  logic       Valid,
    input  logic [1:0] Op,
    input  logic [5:0] Op3,
    input  logic       N_in,
    input  logic       Z_in,
    input  logic       V_in,
    input  logic       C_in,
    input  logic       Is_bicc,
    input  logic [3:0] Cond,
    input  logic       A_bit,
    input  logic       Wr_icc,
    input  logic [3:0] Icc_wdata,
    output logic [3:0] Icc,
    output logic       Cin_out,
    output logic       Branch_taken,
    output logic       Slot_annul
);

    logic [3:0] r_icc;
    bu_state_t  r_state;

    logic       w_ev;
    logic       w_cc_op;
    logic       w_resolved;
    logic [3:0] w_flags;
    logic [3:0] w_eval_icc;
    logic       w_cond_true;
    logic       w_annul;

    assign w_ev       = Valid & ~Slot_annul;
    assign w_cc_op    = is_cc_op(Op, Op3);
    assign w_resolved = w_ev & Is_bicc;
    assign w_flags    = {N_in, Z_in, V_in, C_in};

`ifdef ICC_BYPASS_EN
    // A write to icc in the same cycle wins, so flags are forwarded only without it.
    assign w_eval_icc = (w_ev & w_cc_op & ~Wr_icc) ? w_flags : r_icc;
`else
    assign w_eval_icc = r_icc;
`endif

    bicc_cond_eval u_cond_eval (
        .i_cond  (Cond),
        .i_icc   (w_eval_icc),
        .o_taken (w_cond_true)
    );

    assign Branch_taken = w_resolved & w_cond_true;
    // BA,a annuls its slot even though it is always taken.
    assign w_annul      = A_bit & (~w_cond_true | (Cond == COND_BA));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_icc   <= RESET_ICC;
            r_state <= NORMAL;
        end else if (En) begin
            if (Wr_icc) begin
                r_icc <= Icc_wdata;
            end else if (w_ev & w_cc_op) begin
                r_icc <= w_flags;
            end

            if (w_resolved) begin
                r_state <= w_annul ? ANNUL : DSLOT;
            end else begin
                r_state <= NORMAL;
            end
        end
    end

    assign Icc        = r_icc;
    assign Cin_out    = w_eval_icc[ICC_C];
    assign Slot_annul = (r_state == ANNUL);

endmodule

`default_nettype wire

// File: tb/tb_icc_branch_unit.sv
// ============================================================================
// Module : tb_icc_branch_unit
// Brief  : Directed self-checking bench for icc_branch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icc_branch_unit;

    logic       Clk = 1'b0;
    logic       Rst_n, En, Valid;
    logic [1:0] Op;
    logic [5:0] Op3;
    logic       N_in, Z_in, V_in, C_in;
    logic       Is_bicc, A_bit, Wr_icc;
    logic [3:0] Cond, Icc_wdata;
    logic [3:0] Icc;
    logic       Cin_out, Branch_taken, Slot_annul;

    int n_checks = 0;
    int n_fail   = 0;

    icc_branch_unit #(.RESET_ICC(4'b0000)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Valid(Valid), .Op(Op), .Op3(Op3),
        .N_in(N_in), .Z_in(Z_in), .V_in(V_in), .C_in(C_in),
        .Is_bicc(Is_bicc), .Cond(Cond), .A_bit(A_bit),
        .Wr_icc(Wr_icc), .Icc_wdata(Icc_wdata),
        .Icc(Icc), .Cin_out(Cin_out), .Branch_taken(Branch_taken), .Slot_annul(Slot_annul)
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        Rst_n = 1'b1; En = 1'b1; Valid = 1'b0; Op = 2'b00; Op3 = 6'h00;
        {N_in, Z_in, V_in, C_in} = 4'b0000;
        Is_bicc = 1'b0; Cond = 4'h0; A_bit = 1'b0; Wr_icc = 1'b0; Icc_wdata = 4'h0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_icc(input logic [3:0] val);
        idle();
        Wr_icc = 1'b1; Icc_wdata = val;
        tick();
        idle();
    endtask

    task automatic set_alu(input logic [1:0] op, input logic [5:0] op3, input logic [3:0] fl);
        Valid = 1'b1; Op = op; Op3 = op3; {N_in, Z_in, V_in, C_in} = fl;
    endtask

    task automatic set_br(input logic [3:0] cond, input logic a);
        Valid = 1'b1; Is_bicc = 1'b1; Cond = cond; A_bit = a;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 2; i++) begin
            {Valid, Op, Op3, N_in, Z_in, V_in, C_in} = 13'($urandom);
            {Is_bicc, Cond, A_bit, Wr_icc, Icc_wdata} = 11'($urandom);
            Rst_n = 1'b0; En = 1'($urandom);
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (Icc !== 4'b0000) begin n_fail++; $display("FAIL reset_icc: got %b want 0000", Icc); end
        n_checks++;
        if (Slot_annul !== 1'b0) begin n_fail++; $display("FAIL reset_annul: got %b want 0", Slot_annul); end
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", Branch_taken); end
        n_checks++;
        if (Cin_out !== 1'b0) begin n_fail++; $display("FAIL reset_cin: got %b want 0", Cin_out); end
    endtask

    task automatic test_cc_update();
        idle();
        set_alu(2'b10, 6'h10, 4'b0101);   // ADDcc
        tick();
        idle();
        n_checks++;
        if (Icc !== 4'b0101) begin n_fail++; $display("FAIL addcc_icc: got %b want 0101", Icc); end
        n_checks++;
        if (Cin_out !== 1'b1) begin n_fail++; $display("FAIL addcc_cin: got %b want 1", Cin_out); end
        set_alu(2'b10, 6'h00, 4'b1010);   // ADD
        tick();
        set_alu(2'b10, 6'h25, 4'b1110);   // SLL
        tick();
        set_alu(2'b11, 6'h10, 4'b1000);   // memory op with op3 0x10
        tick();
        set_alu(2'b10, 6'h1C, 4'b0011);   // SUBXcc but not valid
        Valid = 1'b0;
        tick();
        idle();
        n_checks++;
        if (Icc !== 4'b0101) begin n_fail++; $display("FAIL noncc_hold: got %b want 0101", Icc); end
        set_alu(2'b10, 6'h1C, 4'b1001);   // SUBXcc valid
        tick();
        idle();
        n_checks++;
        if (Icc !== 4'b1001) begin n_fail++; $display("FAIL subxcc_icc: got %b want 1001", Icc); end
    endtask

    task automatic test_bicc_decode();
        write_icc(4'b1000);
        set_br(4'd3, 1'b0); #1;
        n_checks++;
        if (Branch_taken !== 1'b1) begin n_fail++; $display("FAIL bl_1000: got %b want 1", Branch_taken); end
        Cond = 4'd0; #1;
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL bn: got %b want 0", Branch_taken); end
        Cond = 4'd6; Valid = 1'b0; #1;
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL bneg_invalid: got %b want 0", Branch_taken); end
        write_icc(4'b1010);
        set_br(4'd3, 1'b0); #1;
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL bl_1010: got %b want 0", Branch_taken); end
        Cond = 4'd12; #1;   // BGU: ~(C|Z) with C=0 Z=0
        n_checks++;
        if (Branch_taken !== 1'b1) begin n_fail++; $display("FAIL bgu_1010: got %b want 1", Branch_taken); end
        write_icc(4'b0000);
        set_br(4'd10, 1'b0); #1;
        n_checks++;
        if (Branch_taken !== 1'b1) begin n_fail++; $display("FAIL bg_0000: got %b want 1", Branch_taken); end
        Cond = 4'd5; #1;
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL bcs_0000: got %b want 0", Branch_taken); end
        idle();
        tick();
    endtask

    task automatic test_annul();
        write_icc(4'b0100);
        set_br(4'd9, 1'b1); #1;           // BNE,a with Z=1: not taken
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL bne_taken: got %b want 0", Branch_taken); end
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b1) begin n_fail++; $display("FAIL bne_annul: got %b want 1", Slot_annul); end
        set_alu(2'b10, 6'h14, 4'b1111);   // SUBcc in annulled slot
        tick();
        idle();
        n_checks++;
        if (Icc !== 4'b0100) begin n_fail++; $display("FAIL annul_subcc_icc: got %b want 0100", Icc); end
        n_checks++;
        if (Slot_annul !== 1'b0) begin n_fail++; $display("FAIL annul_clear: got %b want 0", Slot_annul); end
        set_br(4'd8, 1'b1);               // BA,a
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b1) begin n_fail++; $display("FAIL ba_annul: got %b want 1", Slot_annul); end
        set_br(4'd8, 1'b1); #1;           // branch in the annulled slot is ignored
        n_checks++;
        if (Branch_taken !== 1'b0) begin n_fail++; $display("FAIL annul_slot_br: got %b want 0", Branch_taken); end
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b0) begin n_fail++; $display("FAIL annul_slot_br_next: got %b want 0", Slot_annul); end
        set_br(4'd1, 1'b1); #1;           // BE,a taken
        n_checks++;
        if (Branch_taken !== 1'b1) begin n_fail++; $display("FAIL be_taken: got %b want 1", Branch_taken); end
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b0) begin n_fail++; $display("FAIL be_annul: got %b want 0", Slot_annul); end
        set_br(4'd9, 1'b1);               // DCTI couple: BNE,a in delay slot
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b1) begin n_fail++; $display("FAIL dcti_annul: got %b want 1", Slot_annul); end
        tick();
    endtask

    task automatic test_priority_stall();
        idle();
        set_alu(2'b10, 6'h10, 4'b0000);
        Wr_icc = 1'b1; Icc_wdata = 4'b1111;
        tick();
        idle();
        n_checks++;
        if (Icc !== 4'b1111) begin n_fail++; $display("FAIL wr_priority: got %b want 1111", Icc); end
        set_br(4'd8, 1'b1);
        tick();
        idle();
        En = 1'b0; Wr_icc = 1'b1; Icc_wdata = 4'b0000;
        set_alu(2'b10, 6'h10, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Slot_annul !== 1'b1) begin n_fail++; $display("FAIL stall_annul[%0d]: got %b want 1", i, Slot_annul); end
        end
        n_checks++;
        if (Icc !== 4'b1111) begin n_fail++; $display("FAIL stall_icc: got %b want 1111", Icc); end
        idle();
        tick();
        n_checks++;
        if (Slot_annul !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", Slot_annul); end
        set_br(4'd8, 1'b1);
        tick();
        idle();
        Rst_n = 1'b0;
        tick();
        idle();
        n_checks++;
        if (Slot_annul !== 1'b0 || Icc !== 4'b0000) begin
            n_fail++; $display("FAIL reset_midbranch: got annul=%b icc=%b want 0 0000", Slot_annul, Icc);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_same;
`ifdef ICC_BYPASS_EN
        exp_same = 1'b1;
`else
        exp_same = 1'b0;
`endif
        write_icc(4'b0000);
        set_alu(2'b10, 6'h14, 4'b0101);   // SUBcc Z=1 C=1
        set_br(4'd1, 1'b0); #1;           // concurrent BE
        n_checks++;
        if (Branch_taken !== exp_same) begin n_fail++; $display("FAIL bypass_taken: got %b want %b", Branch_taken, exp_same); end
        n_checks++;
        if (Cin_out !== exp_same) begin n_fail++; $display("FAIL bypass_cin: got %b want %b", Cin_out, exp_same); end
        tick();
        idle();
        set_br(4'd1, 1'b0); #1;           // BE right after the cc-op
        n_checks++;
        if (Branch_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_taken: got %b want 1", Branch_taken); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        Rst_n = 1'b0;
        test_reset();
        test_cc_update();
        test_bicc_decode();
        test_annul();
        test_priority_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
